// File: rtl/queue_2x64_ctrl.sv
// Control logic for a two-entry, 64-bit queue built around an external 2x64 RAM.
// The block holds only the pointers and the full/empty disambiguation bit; payload
// data lives in the external storage, which is written through W0 and read through R0.
// Both storage ports share this block's clock externally.
module queue_2x64_ctrl #(
  parameter bit FLOW = 1'b0,  // empty-queue bypass from enq to deq in the same cycle
  parameter bit PIPE = 1'b0   // accept an enq while full if a deq happens in the same cycle
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  // producer handshake
  input  logic        enq_valid,
  output logic        enq_ready,
  input  logic [63:0] enq_bits,
  // consumer handshake
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [63:0] deq_bits,
  // occupancy, 0..2
  output logic [1:0]  count,
  // storage write port
  output logic        ram_W0_addr,
  output logic        ram_W0_en,
  output logic [63:0] ram_W0_data,
  // storage read port, data combinational from address
  output logic        ram_R0_addr,
  output logic        ram_R0_en,
  input  logic [63:0] ram_R0_data
);

  logic enq_ptr_q, enq_ptr_d;
  logic deq_ptr_q, deq_ptr_d;
  logic maybe_full_q, maybe_full_d;

  logic ptr_match;
  logic empty;
  logic full;
  logic bypass;
  logic do_enq;
  logic do_deq;

  // Status decode and handshake qualification.
  always_comb begin
    ptr_match = (enq_ptr_q == deq_ptr_q);
    empty     = ptr_match & ~maybe_full_q;
    full      = ptr_match & maybe_full_q;

    // Flush masks both ready and valid, so no handshake can fire in a flush cycle.
    enq_ready = ~flush & (~full | (PIPE & deq_ready));
    deq_valid = ~flush & (~empty | (FLOW & enq_valid));

    // With FLOW, an empty queue hands the word straight through: no write when the
    // consumer takes it now, and never any pointer movement on the deq side.
    bypass = FLOW & empty;
    do_enq = enq_valid & enq_ready & ~(bypass & deq_ready);
    do_deq = deq_valid & deq_ready & ~bypass;
  end

  // Output drive: occupancy, storage ports and dequeued data.
  always_comb begin
    if (full) begin
      count = 2'd2;
    end else if (!ptr_match) begin
      count = 2'd1;
    end else begin
      count = 2'd0;
    end

    ram_W0_en   = do_enq;
    ram_W0_addr = enq_ptr_q;
    ram_W0_data = enq_bits;

    // Read enable tied high so read data never goes unknown because of the enable.
    ram_R0_en   = 1'b1;
    ram_R0_addr = deq_ptr_q;

    deq_bits    = bypass ? enq_bits : ram_R0_data;
  end

  // Next-state: flush clears everything, otherwise pointers toggle on their handshakes.
  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (flush) begin
      enq_ptr_d    = 1'b0;
      deq_ptr_d    = 1'b0;
      maybe_full_d = 1'b0;
    end else begin
      if (do_enq) begin
        enq_ptr_d = ~enq_ptr_q;
      end
      if (do_deq) begin
        deq_ptr_d = ~deq_ptr_q;
      end
      // Equal pointers are ambiguous; the last unbalanced operation says which way.
      if (do_enq != do_deq) begin
        maybe_full_d = do_enq;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr_q    <= 1'b0;
      deq_ptr_q    <= 1'b0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

endmodule

// File: tb/tb_queue_2x64_ctrl.sv
// Self-checking bench for queue_2x64_ctrl: three instances (plain, FLOW, PIPE), each
// with its own 2x64 storage model, driven from a table of directed vectors plus a
// hand-written asynchronous reset sequence.
`timescale 1ns/1ps
module tb_queue_2x64_ctrl;

  logic clock;
  logic reset_n;

  logic [2:0]  flush_s, ev_s, dr_s;
  logic [63:0] eb_s [3];
  logic [2:0]  er_s, dv_s, wen_s, wa_s, ren_s, ra_s;
  logic [63:0] db_s [3];
  logic [63:0] wd_s [3];
  logic [63:0] rd_s [3];
  logic [1:0]  cnt_s [3];

  logic [63:0] mem [3][2];

  int n_cmp;
  int n_bad;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Storage models: synchronous write, combinational read.
  always @(posedge clock) begin
    for (int d = 0; d < 3; d++) begin
      if (wen_s[d]) mem[d][wa_s[d]] <= wd_s[d];
    end
  end
  assign rd_s[0] = mem[0][ra_s[0]];
  assign rd_s[1] = mem[1][ra_s[1]];
  assign rd_s[2] = mem[2][ra_s[2]];

  queue_2x64_ctrl #(.FLOW(1'b0), .PIPE(1'b0)) u_plain (
    .clock(clock), .reset_n(reset_n), .flush(flush_s[0]),
    .enq_valid(ev_s[0]), .enq_ready(er_s[0]), .enq_bits(eb_s[0]),
    .deq_valid(dv_s[0]), .deq_ready(dr_s[0]), .deq_bits(db_s[0]),
    .count(cnt_s[0]),
    .ram_W0_addr(wa_s[0]), .ram_W0_en(wen_s[0]), .ram_W0_data(wd_s[0]),
    .ram_R0_addr(ra_s[0]), .ram_R0_en(ren_s[0]), .ram_R0_data(rd_s[0])
  );

  queue_2x64_ctrl #(.FLOW(1'b1), .PIPE(1'b0)) u_flow (
    .clock(clock), .reset_n(reset_n), .flush(flush_s[1]),
    .enq_valid(ev_s[1]), .enq_ready(er_s[1]), .enq_bits(eb_s[1]),
    .deq_valid(dv_s[1]), .deq_ready(dr_s[1]), .deq_bits(db_s[1]),
    .count(cnt_s[1]),
    .ram_W0_addr(wa_s[1]), .ram_W0_en(wen_s[1]), .ram_W0_data(wd_s[1]),
    .ram_R0_addr(ra_s[1]), .ram_R0_en(ren_s[1]), .ram_R0_data(rd_s[1])
  );

  queue_2x64_ctrl #(.FLOW(1'b0), .PIPE(1'b1)) u_pipe (
    .clock(clock), .reset_n(reset_n), .flush(flush_s[2]),
    .enq_valid(ev_s[2]), .enq_ready(er_s[2]), .enq_bits(eb_s[2]),
    .deq_valid(dv_s[2]), .deq_ready(dr_s[2]), .deq_bits(db_s[2]),
    .count(cnt_s[2]),
    .ram_W0_addr(wa_s[2]), .ram_W0_en(wen_s[2]), .ram_W0_data(wd_s[2]),
    .ram_R0_addr(ra_s[2]), .ram_R0_en(ren_s[2]), .ram_R0_data(rd_s[2])
  );

  typedef struct {
    int          sel;
    logic        fl;
    logic        ev;
    logic [63:0] eb;
    logic        dr;
    logic [1:0]  cnt;
    logic        er;
    logic        dv;
    logic [63:0] db;
    logic        chk_db;
    logic        wen;
    logic        wa;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int sel, logic fl, logic ev, logic [63:0] eb, logic dr,
                              logic [1:0] cnt, logic er, logic dv, logic [63:0] db,
                              logic chk_db, logic wen, logic wa);
    vec_t v;
    v.sel = sel; v.fl = fl; v.ev = ev; v.eb = eb; v.dr = dr;
    v.cnt = cnt; v.er = er; v.dv = dv; v.db = db; v.chk_db = chk_db;
    v.wen = wen; v.wa = wa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    flush_s = '0; ev_s = '0; dr_s = '0;
    for (int d = 0; d < 3; d++) eb_s[d] = '0;
  endtask

  // Drive one vector mid-cycle, check outputs before the next rising edge.
  task automatic apply(input int idx, input vec_t v);
    string p;
    @(negedge clock);
    idle_all();
    flush_s[v.sel] = v.fl;
    ev_s[v.sel]    = v.ev;
    eb_s[v.sel]    = v.eb;
    dr_s[v.sel]    = v.dr;
    #1;
    p = $sformatf("v%0d/dut%0d", idx, v.sel);
    chk({p, ".count"}, 64'(cnt_s[v.sel]), 64'(v.cnt));
    chk({p, ".enq_ready"}, 64'(er_s[v.sel]), 64'(v.er));
    chk({p, ".deq_valid"}, 64'(dv_s[v.sel]), 64'(v.dv));
    chk({p, ".w_en"}, 64'(wen_s[v.sel]), 64'(v.wen));
    chk({p, ".w_addr"}, 64'(wa_s[v.sel]), 64'(v.wa));
    chk({p, ".r_en"}, 64'(ren_s[v.sel]), 64'd1);
    if (v.chk_db) chk({p, ".deq_bits"}, db_s[v.sel], v.db);
    if (v.wen) chk({p, ".w_data"}, wd_s[v.sel], v.eb);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_all();
    reset_n = 1'b0;

    // Plain queue: fill to two, drain in order, then simultaneous enq/deq at count 1,
    // then fill and flush with a competing enq.
    //                sel fl ev  eb        dr  cnt er dv db        cdb wen wa
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 1, 0, 64'h0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 64'hA,    0, 0, 1, 0, 64'h0,    0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 64'hB,    0, 1, 1, 1, 64'hA,    1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 64'hDD,   0, 2, 0, 1, 64'hA,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,    1, 2, 0, 1, 64'hA,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,    1, 1, 1, 1, 64'hB,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 1, 0, 64'h0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h11,   0, 0, 1, 0, 64'h0,    0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 64'hC,    1, 1, 1, 1, 64'h11,   1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 1, 1, 1, 64'hC,    1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h22,   0, 1, 1, 1, 64'hC,    1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 64'h33,   0, 2, 0, 1, 64'hC,    1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 64'h44,   1, 2, 0, 0, 64'h0,    0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 1, 0, 64'h0,    0, 0, 0));
    // FLOW queue: same-cycle bypass, bypass without consumer, then normal traffic.
    vecs.push_back(mk(1, 0, 1, 64'h5,    1, 0, 1, 1, 64'h5,    1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,    0, 0, 1, 0, 64'h0,    0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 64'h66,   0, 0, 1, 1, 64'h66,   1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 64'h77,   1, 1, 1, 1, 64'h66,   1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,    0, 1, 1, 1, 64'h77,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 64'h0,    0, 1, 0, 0, 64'h0,    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,    0, 0, 1, 0, 64'h0,    0, 0, 0));
    // PIPE queue: fill, enq+deq while full, drain in FIFO order.
    vecs.push_back(mk(2, 0, 1, 64'hA1,   0, 0, 1, 0, 64'h0,    0, 1, 0));
    vecs.push_back(mk(2, 0, 1, 64'hA2,   0, 1, 1, 1, 64'hA1,   1, 1, 1));
    vecs.push_back(mk(2, 0, 1, 64'hA3,   0, 2, 0, 1, 64'hA1,   1, 0, 0));
    vecs.push_back(mk(2, 0, 1, 64'hA3,   1, 2, 1, 1, 64'hA1,   1, 1, 0));
    vecs.push_back(mk(2, 0, 0, 64'h0,    1, 2, 1, 1, 64'hA2,   1, 0, 1));
    vecs.push_back(mk(2, 0, 0, 64'h0,    1, 1, 1, 1, 64'hA3,   1, 0, 1));
    vecs.push_back(mk(2, 0, 0, 64'h0,    0, 0, 1, 0, 64'h0,    0, 0, 1));

    // Outputs while reset is held.
    repeat (2) @(negedge clock);
    #1;
    chk("rst.count", 64'(cnt_s[0]), 64'd0);
    chk("rst.deq_valid", 64'(dv_s[0]), 64'd0);
    chk("rst.enq_ready", 64'(er_s[0]), 64'd1);
    chk("rst.w_en", 64'(wen_s[0]), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Asynchronous reset off the clock edge with one entry queued.
    @(negedge clock);
    idle_all();
    ev_s[0] = 1'b1;
    eb_s[0] = 64'h99;
    @(negedge clock);
    idle_all();
    #1;
    chk("arst.pre_count", 64'(cnt_s[0]), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst.count", 64'(cnt_s[0]), 64'd0);
    chk("arst.deq_valid", 64'(dv_s[0]), 64'd0);
    chk("arst.enq_ready", 64'(er_s[0]), 64'd1);
    #1 reset_n = 1'b1;
    @(negedge clock);
    ev_s[0] = 1'b1;
    eb_s[0] = 64'hBB;
    #1;
    chk("arst.post_w_en", 64'(wen_s[0]), 64'd1);
    chk("arst.post_w_addr", 64'(wa_s[0]), 64'd0);
    @(negedge clock);
    idle_all();
    #1;
    chk("arst.post_count", 64'(cnt_s[0]), 64'd1);
    chk("arst.post_deq_bits", db_s[0], 64'hBB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/queue_2x64_ctrl.md
QUEUE_2X64_CTRL -- requirements
Module: queue_2x64_ctrl

Interface
REQ-001 The block SHALL have parameter FLOW, default 0: when 1, data entering an empty queue passes combinationally to deq in the same cycle.
REQ-002 The block SHALL have parameter PIPE, default 0: when 1, enq_ready is also asserted when full and deq_ready is high.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous queue clear.
REQ-006 The block SHALL have ports enq_valid (input, 1), enq_ready (output, 1) and enq_bits (input, 64): the producer handshake.
REQ-007 The block SHALL have ports deq_valid (output, 1), deq_ready (input, 1) and deq_bits (output, 64): the consumer handshake.
REQ-008 The block SHALL have port count, output, 2 bits: current occupancy, 0..2.
REQ-009 The block SHALL have ports ram_W0_addr (output, 1), ram_W0_en (output, 1) and ram_W0_data (output, 64): the storage write port.
REQ-010 The block SHALL have ports ram_R0_addr (output, 1), ram_R0_en (output, 1) and ram_R0_data (input, 64): the storage read port; read data is combinational from the address.
REQ-011 The block SHALL connect the storage W0_clk and R0_clk to the same clock externally; the block SHALL contain no storage for payload data itself.

Function
REQ-012 The block SHALL hold state enq_ptr (1 bit), deq_ptr (1 bit) and maybe_full (1 bit).
REQ-013 The block SHALL define empty = (enq_ptr==deq_ptr) & ~maybe_full and full = (enq_ptr==deq_ptr) & maybe_full.
REQ-014 The block SHALL drive count = 2 when full, 1 when enq_ptr!=deq_ptr, and 0 otherwise.
REQ-015 The block SHALL drive enq_ready = ~flush & (~full | (PIPE & deq_ready)).
REQ-016 The block SHALL drive deq_valid = ~flush & (~empty | (FLOW & enq_valid)).
REQ-017 The block SHALL define do_enq = enq_valid & enq_ready, except that with FLOW=1, empty and deq_ready high, do_enq SHALL be 0 (bypass, no write).
REQ-018 The block SHALL define do_deq = deq_valid & deq_ready, except that with FLOW=1 and empty, do_deq SHALL be 0 (no pointer movement).
REQ-019 The block SHALL drive ram_W0_en = do_enq, ram_W0_addr = enq_ptr and ram_W0_data = enq_bits.
REQ-020 The block SHALL drive ram_R0_en = 1 and ram_R0_addr = deq_ptr, so that read data is never X from the enable.
REQ-021 The block SHALL drive deq_bits = enq_bits when FLOW=1 and empty, and ram_R0_data otherwise.
REQ-022 On a clock edge, if do_enq, enq_ptr SHALL toggle (wrap 1->0).
REQ-023 On a clock edge, if do_deq, deq_ptr SHALL toggle (wrap 1->0).
REQ-024 On a clock edge where do_enq != do_deq, maybe_full SHALL be set to do_enq.
REQ-025 Simultaneous enq and deq when count is 1 SHALL leave count at 1 and move both pointers.
REQ-026 With PIPE=1, simultaneous enq and deq when full SHALL leave count at 2.
REQ-027 Flush SHALL take precedence over any handshake: on an edge with flush=1, enq_ptr, deq_ptr and maybe_full SHALL clear to 0, and ram_W0_en SHALL be 0 in that cycle.
REQ-028 The latency from an accepted enq to deq_valid SHALL be 1 cycle (0 cycles with FLOW=1 when empty).
REQ-029 Once deq_valid is high, deq_bits SHALL remain stable until do_deq or flush.

Reset
REQ-030 While reset_n is low, enq_ptr, deq_ptr and maybe_full SHALL be 0 asynchronously.
REQ-031 During reset, the outputs SHALL be: count=0, deq_valid=0 (FLOW=0), enq_ready=1 (flush=0), ram_W0_en=0.
REQ-032 Reset asserted mid-transfer SHALL discard all queued entries; the first enq after release SHALL write address 0.

Verification
REQ-033 FLOW=0, PIPE=0: enq 0xA, then 0xB, with deq_ready=0 -> count=2, enq_ready=0; then deq_ready=1 for 2 cycles -> deq_bits 0xA, then 0xB; count returns to 0.
REQ-034 Count=1, enq 0xC and deq in the same cycle -> count stays 1, deq_bits=0xC next cycle, pointers wrapped.
REQ-035 FLOW=1, empty: enq_valid=1, enq_bits=0x5, deq_ready=1 -> deq_valid=1 and deq_bits=0x5 in the same cycle, ram_W0_en=0, count stays 0.
REQ-036 PIPE=1, full: enq_valid=1, deq_ready=1 -> enq_ready=1, count stays 2, FIFO order preserved.
REQ-037 Full, then flush=1 together with enq_valid=1 -> no write, count=0 next cycle, deq_valid=0.
REQ-038 reset_n pulsed low asynchronously (off a clock edge) while count=1 -> count=0 immediately; the next enq writes ram_W0_addr=0.
